// File: rtl/rom_loader.sv
// ============================================================================
// Module   : rom_loader
// Purpose  : Copies a combinational program ROM byte by byte into a writable
//            memory through a request/ack write port; holds busy until done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'd0,
  parameter logic [31:0] MAX_BYTES    = 32'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic [31:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_write_request,
  input  logic        mem_write_ack,
  output logic        busy,
  output logic        finished,
  output logic        error,
  output logic [31:0] byte_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state,       w_state;
  logic [31:0] r_rom_address, w_rom_address;
  logic [31:0] r_mem_address, w_mem_address;
  logic [7:0]  r_mem_data,    w_mem_data;
  logic        r_req,         w_req;
  logic        r_busy,        w_busy;
  logic        r_finished,    w_finished;
  logic        r_error,       w_error;
  logic [31:0] r_byte_count,  w_byte_count;
  logic        r_last,        w_last;
  logic        r_ok,          w_ok;   // completion kind carried into DONE
  logic [31:0] w_count_inc;

  assign w_count_inc = r_byte_count + 32'd1;

  always_comb begin
    w_state       = r_state;
    w_rom_address = r_rom_address;
    w_mem_address = r_mem_address;
    w_mem_data    = r_mem_data;
    w_req         = r_req;
    w_busy        = r_busy;
    w_finished    = r_finished;
    w_error       = r_error;
    w_byte_count  = r_byte_count;
    w_last        = r_last;
    w_ok          = r_ok;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rom_address = 32'd0;
          w_byte_count  = 32'd0;
          w_finished    = 1'b0;
          w_error       = 1'b0;
          w_busy        = 1'b1;
          w_state       = S_FETCH;
        end
      end
      S_FETCH: begin
        w_mem_data    = rom_byte;
        w_last        = rom_done;
        w_mem_address = BASE_ADDRESS + r_rom_address;
        w_req         = 1'b1;
        w_state       = S_WRITE;
      end
      S_WRITE: begin
        if (mem_write_ack) begin
          w_req        = 1'b0;
          w_byte_count = w_count_inc;
          if (r_last) begin
            w_ok    = 1'b1;
            w_state = S_DONE;
          end else if (w_count_inc == MAX_BYTES) begin
            w_ok    = 1'b0;
            w_state = S_DONE;
          end else begin
            w_rom_address = r_rom_address + 32'd1;
            w_state       = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_busy     = 1'b0;
        w_finished = r_ok;
        w_error    = ~r_ok;
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rom_address <= 32'd0;
      r_mem_address <= 32'd0;
      r_mem_data    <= 8'd0;
      r_req         <= 1'b0;
      r_busy        <= 1'b0;
      r_finished    <= 1'b0;
      r_error       <= 1'b0;
      r_byte_count  <= 32'd0;
      r_last        <= 1'b0;
      r_ok          <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_rom_address <= w_rom_address;
      r_mem_address <= w_mem_address;
      r_mem_data    <= w_mem_data;
      r_req         <= w_req;
      r_busy        <= w_busy;
      r_finished    <= w_finished;
      r_error       <= w_error;
      r_byte_count  <= w_byte_count;
      r_last        <= w_last;
      r_ok          <= w_ok;
    end
  end

  assign rom_address       = r_rom_address;
  assign mem_address       = r_mem_address;
  assign mem_data          = r_mem_data;
  assign mem_write_request = r_req;
  assign busy              = r_busy;
  assign finished          = r_finished;
  assign error             = r_error;
  assign byte_count        = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
// Module   : tb_rom_loader
// Purpose  : Self-checking bench for rom_loader against a ROM/write-list model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rom_loader;

  localparam int NB = 165;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] rom [0:255];
  int n_cmp  = 0;
  int n_fail = 0;

  // dut_a: defaults; dut_b: BASE 0x1000 with slow ack; dut_c: MAX_BYTES 16
  logic        start_a, start_b, start_c;
  logic [31:0] rom_address_a, rom_address_b, rom_address_c;
  logic [7:0]  rom_byte_a, rom_byte_b, rom_byte_c;
  logic        rom_done_a, rom_done_b, rom_done_c;
  logic [31:0] mem_address_a, mem_address_b, mem_address_c;
  logic [7:0]  mem_data_a, mem_data_b, mem_data_c;
  logic        req_a, req_b, req_c;
  logic        ack_a, ack_b, ack_c;
  logic        busy_a, busy_b, busy_c;
  logic        finished_a, finished_b, finished_c;
  logic        error_a, error_b, error_c;
  logic [31:0] byte_count_a, byte_count_b, byte_count_c;

  assign rom_byte_a = rom[rom_address_a[7:0]];
  assign rom_byte_b = rom[rom_address_b[7:0]];
  assign rom_byte_c = rom[rom_address_c[7:0]];
  assign rom_done_a = (rom_address_a == 32'd164);
  assign rom_done_b = (rom_address_b == 32'd164);
  assign rom_done_c = 1'b0;

  rom_loader u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rom_address(rom_address_a),
    .rom_byte(rom_byte_a), .rom_done(rom_done_a), .mem_address(mem_address_a),
    .mem_data(mem_data_a), .mem_write_request(req_a), .mem_write_ack(ack_a),
    .busy(busy_a), .finished(finished_a), .error(error_a), .byte_count(byte_count_a));

  rom_loader #(.BASE_ADDRESS(32'h1000)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rom_address(rom_address_b),
    .rom_byte(rom_byte_b), .rom_done(rom_done_b), .mem_address(mem_address_b),
    .mem_data(mem_data_b), .mem_write_request(req_b), .mem_write_ack(ack_b),
    .busy(busy_b), .finished(finished_b), .error(error_b), .byte_count(byte_count_b));

  rom_loader #(.MAX_BYTES(32'd16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .rom_address(rom_address_c),
    .rom_byte(rom_byte_c), .rom_done(rom_done_c), .mem_address(mem_address_c),
    .mem_data(mem_data_c), .mem_write_request(req_c), .mem_write_ack(ack_c),
    .busy(busy_c), .finished(finished_c), .error(error_c), .byte_count(byte_count_c));

  // Accepted-write logs: a write is accepted at the edge following a
  // falling-edge sample that shows request and ack both high.
  logic [31:0] wa_a[$], wa_b[$], wa_c[$];
  logic [7:0]  wd_a[$], wd_b[$], wd_c[$];
  int          hold_a[$], hold_b[$];
  int          hc_a = 0, hc_b = 0, stab_b = 0, cnt_b = 0;
  logic [31:0] pa_b;
  logic [7:0]  pd_b;

  always @(negedge clk) begin
    if (!rst_n || !req_a) hc_a = 0;
    else begin
      hc_a++;
      if (ack_a) begin
        wa_a.push_back(mem_address_a); wd_a.push_back(mem_data_a);
        hold_a.push_back(hc_a); hc_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !req_b) hc_b = 0;
    else begin
      if (hc_b > 0 && (mem_address_b !== pa_b || mem_data_b !== pd_b)) stab_b++;
      hc_b++;
      pa_b = mem_address_b;
      pd_b = mem_data_b;
      if (ack_b) begin
        wa_b.push_back(mem_address_b); wd_b.push_back(mem_data_b);
        hold_b.push_back(hc_b); hc_b = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && req_c && ack_c) begin
      wa_c.push_back(mem_address_c); wd_c.push_back(mem_data_c);
    end
  end

  // Slow memory for dut_b: ack raised on the 4th request cycle.
  always @(posedge clk) begin
    #1;
    if (!rst_n || ack_b) begin
      ack_b = 1'b0; cnt_b = 0;
    end else if (req_b) begin
      cnt_b++;
      if (cnt_b == 4) ack_b = 1'b1;
    end else cnt_b = 0;
  end

  function automatic int nw(input int which);
    if (which == 0) return wa_a.size();
    if (which == 1) return wa_b.size();
    return wa_c.size();
  endfunction

  task automatic wait_writes(input int which, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (nw(which) >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (nw(which) >= n) ok = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({rom_address_a, mem_address_a, mem_data_a, req_a, busy_a, finished_a, error_a, byte_count_a} !== 108'd0) begin
      n_fail++; $display("FAIL reset_a: outputs not zero (busy=%b req=%b cnt=%0d)", busy_a, req_a, byte_count_a);
    end
    n_cmp++;
    if ({rom_address_b, mem_address_b, mem_data_b, req_b, busy_b, finished_b, error_b, byte_count_b} !== 108'd0) begin
      n_fail++; $display("FAIL reset_b: outputs not zero (busy=%b req=%b cnt=%0d)", busy_b, req_b, byte_count_b);
    end
    n_cmp++;
    if ({rom_address_c, mem_address_c, mem_data_c, req_c, busy_c, finished_c, error_c, byte_count_c} !== 108'd0) begin
      n_fail++; $display("FAIL reset_c: outputs not zero (busy=%b req=%b cnt=%0d)", busy_c, req_c, byte_count_c);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || req_a !== 1'b0 || wa_a.size() != 0) begin
      n_fail++; $display("FAIL idle_hold: busy=%b req=%b writes=%0d, expected 0/0/0", busy_a, req_a, wa_a.size());
    end
  endtask

  task automatic test_copy_basic;
    bit ok;
    wa_a.delete(); wd_a.delete(); hold_a.delete();
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_a); end
    wait_writes(0, NB, 2000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: writes=%0d expected %0d", wa_a.size(), NB); end
    n_cmp++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 1 one cycle after last ack", busy_a); end
    @(posedge clk); #1;
    n_cmp++;
    if (busy_a !== 1'b0 || finished_a !== 1'b1 || error_a !== 1'b0 || byte_count_a !== 32'd165) begin
      n_fail++; $display("FAIL basic_end: busy=%b fin=%b err=%b cnt=%0d expected 0/1/0/165", busy_a, finished_a, error_a, byte_count_a);
    end
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if (wa_a.size() != NB) begin n_fail++; $display("FAIL basic_count: writes=%0d expected %0d", wa_a.size(), NB); end
    for (int i = 0; i < NB && i < wa_a.size(); i++) begin
      n_cmp++;
      if (wa_a[i] !== 32'(i) || wd_a[i] !== rom[i] || hold_a[i] != 1) begin
        n_fail++; $display("FAIL basic_write[%0d]: addr=%h data=%h hold=%0d expected %h/%h/1", i, wa_a[i], wd_a[i], hold_a[i], 32'(i), rom[i]);
      end
    end
  endtask

  task automatic test_base_delayed;
    bit ok;
    wa_b.delete(); wd_b.delete(); hold_b.delete(); stab_b = 0;
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    wait_writes(1, NB, 1500, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL base_timeout: writes=%0d expected %0d", wa_b.size(), NB); end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (busy_b !== 1'b0 || finished_b !== 1'b1 || error_b !== 1'b0 || byte_count_b !== 32'd165) begin
      n_fail++; $display("FAIL base_end: busy=%b fin=%b err=%b cnt=%0d expected 0/1/0/165", busy_b, finished_b, error_b, byte_count_b);
    end
    n_cmp++;
    if (stab_b != 0) begin n_fail++; $display("FAIL base_stable: %0d unstable cycles expected 0", stab_b); end
    n_cmp++;
    if (wa_b.size() != NB) begin n_fail++; $display("FAIL base_count: writes=%0d expected %0d", wa_b.size(), NB); end
    for (int i = 0; i < NB && i < wa_b.size(); i++) begin
      n_cmp++;
      if (wa_b[i] !== 32'h1000 + 32'(i) || wd_b[i] !== rom[i] || hold_b[i] != 4) begin
        n_fail++; $display("FAIL base_write[%0d]: addr=%h data=%h hold=%0d expected %h/%h/4", i, wa_b[i], wd_b[i], hold_b[i], 32'h1000 + 32'(i), rom[i]);
      end
    end
  endtask

  task automatic test_max_bytes;
    bit ok;
    wa_c.delete(); wd_c.delete();
    start_c = 1'b1; @(posedge clk); #1; start_c = 1'b0;
    wait_writes(2, 16, 200, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL max_timeout: writes=%0d expected 16", wa_c.size()); end
    repeat (8) @(posedge clk); #1;
    n_cmp++;
    if (busy_c !== 1'b0 || finished_c !== 1'b0 || error_c !== 1'b1 || byte_count_c !== 32'd16 || wa_c.size() != 16) begin
      n_fail++; $display("FAIL max_end: busy=%b fin=%b err=%b cnt=%0d writes=%0d expected 0/0/1/16/16",
                         busy_c, finished_c, error_c, byte_count_c, wa_c.size());
    end
    for (int i = 0; i < 16 && i < wa_c.size(); i++) begin
      n_cmp++;
      if (wa_c[i] !== 32'(i) || wd_c[i] !== rom[i]) begin
        n_fail++; $display("FAIL max_write[%0d]: addr=%h data=%h expected %h/%h", i, wa_c[i], wd_c[i], 32'(i), rom[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    bit ok;
    int c;
    wa_b.delete(); wd_b.delete(); hold_b.delete();
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    wait_writes(1, 50, 600, ok);
    c = 0;
    while (!req_b && c < 20) begin @(posedge clk); #1; c++; end
    n_cmp++;
    if (!ok || req_b !== 1'b1 || wa_b.size() != 50) begin
      n_fail++; $display("FAIL midrst_setup: writes=%0d req=%b expected 50/1", wa_b.size(), req_b);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rom_address_b, mem_address_b, mem_data_b, req_b, busy_b, finished_b, error_b, byte_count_b} !== 108'd0) begin
      n_fail++; $display("FAIL midrst_zero: req=%b busy=%b cnt=%0d addr=%h expected all 0", req_b, busy_b, byte_count_b, mem_address_b);
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    n_cmp++;
    if (wa_b.size() != 50 || req_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++; $display("FAIL midrst_quiet: writes=%0d req=%b busy=%b expected 50/0/0", wa_b.size(), req_b, busy_b);
    end
    wa_b.delete(); wd_b.delete(); hold_b.delete();
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
    wait_writes(1, NB, 1500, ok);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (!ok || wa_b.size() != NB || wa_b[0] !== 32'h1000 || wd_b[0] !== rom[0] || finished_b !== 1'b1) begin
      n_fail++; $display("FAIL midrst_restart: writes=%0d first=%h/%h fin=%b expected %0d 00001000/%h 1",
                         wa_b.size(), wa_b.size() ? wa_b[0] : 32'hx, wd_b.size() ? wd_b[0] : 8'hx, finished_b, NB, rom[0]);
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    wa_a.delete(); wd_a.delete(); hold_a.delete();
    start_a = 1'b1; @(posedge clk); #1;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      start_a = busy_a ? 1'($urandom_range(0, 1)) : 1'b0;
      if (wa_a.size() >= NB) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    start_a = 1'b1;              // held through the DONE cycle
    @(posedge clk); #1;
    start_a = 1'b0;
    n_cmp++;
    if (!ok || busy_a !== 1'b0 || finished_a !== 1'b1 || byte_count_a !== 32'd165) begin
      n_fail++; $display("FAIL b2b_end: busy=%b fin=%b cnt=%0d expected 0/1/165", busy_a, finished_a, byte_count_a);
    end
    repeat (5) @(posedge clk); #1;
    n_cmp++;
    if (wa_a.size() != NB || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL b2b_count: writes=%0d busy=%b expected %0d/0", wa_a.size(), busy_a, NB);
    end
    for (int i = 0; i < NB && i < wa_a.size(); i++) begin
      n_cmp++;
      if (wa_a[i] !== 32'(i) || wd_a[i] !== rom[i]) begin
        n_fail++; $display("FAIL b2b_write[%0d]: addr=%h data=%h expected %h/%h", i, wa_a[i], wd_a[i], 32'(i), rom[i]);
      end
    end
  endtask

  task automatic test_restart;
    bit ok;
    wa_a.delete(); wd_a.delete(); hold_a.delete();
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
    n_cmp++;
    if (finished_a !== 1'b0 || error_a !== 1'b0 || busy_a !== 1'b1 || byte_count_a !== 32'd0) begin
      n_fail++; $display("FAIL restart_clear: fin=%b err=%b busy=%b cnt=%0d expected 0/0/1/0", finished_a, error_a, busy_a, byte_count_a);
    end
    wait_writes(0, NB, 2000, ok);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (!ok || wa_a.size() != NB || wa_a[0] !== 32'd0 || finished_a !== 1'b1 || byte_count_a !== 32'd165) begin
      n_fail++; $display("FAIL restart_end: writes=%0d fin=%b cnt=%0d expected %0d/1/165", wa_a.size(), finished_a, byte_count_a, NB);
    end
  endtask

  initial begin
    ack_a = 1'b1;
    ack_b = 1'b0;
    ack_c = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'd1; rom[1] = 8'd0; rom[2] = 8'd0; rom[3] = 8'd0;
    rom[130] = 8'd45;
    rom[148] = 8'd135;
    test_reset();
    test_copy_basic();
    test_base_delayed();
    test_max_bytes();
    test_reset_mid_write();
    test_start_ignored();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sequencer that copies the combinational program ROM, byte by byte, into a byte-wide writable memory (RAM/instruction store) after reset or on command.
- Drives the ROM address, captures each output byte and the ROM's last-byte flag, and issues one request/ack write per byte to the memory port at a base offset.
- Sits between the program ROM and the memory write port; the CPU core is held off (busy) until the copy finishes.

Parameters:
- BASE_ADDRESS, 32'd0, memory address that receives ROM byte 0.
- MAX_BYTES, 32'd4096, safety limit; the copy stops with error if the ROM done flag is not seen within this many bytes.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin copy; sampled only in IDLE
- rom_address  output  32  byte address to ROM
- rom_byte  input  8  ROM data for rom_address, combinational, same cycle
- rom_done  input  1  high when rom_address is the last valid ROM byte
- mem_address  output  32  write address = BASE_ADDRESS + byte index
- mem_data  output  8  write data
- mem_write_request  output  1  write request, held until acked
- mem_write_ack  input  1  memory accepted write (sampled at rising edge while request high)
- busy  output  1  high from start acceptance until copy ends
- finished  output  1  sticky, copy completed normally
- error  output  1  sticky, MAX_BYTES reached without rom_done
- byte_count  output  32  bytes successfully written in the current or last copy

Behaviour:
- Async reset (rst_n low) forces state IDLE and all outputs to 0, including finished, error, byte_count, and rom_address. Reset mid-copy abandons the copy with no further requests.
- All outputs are registered.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - On start=1: rom_address<=0, byte_count<=0, finished<=0, error<=0, busy<=1, go to FETCH.
  - Otherwise hold.
- FETCH (exactly 1 cycle):
  - mem_data<=rom_byte, last<=rom_done, mem_address<=BASE_ADDRESS+rom_address.
  - mem_write_request<=1, go to WRITE.
- WRITE:
  - mem_address, mem_data and the request stay stable until the ack is sampled.
  - On an edge with mem_write_ack=1: request<=0, byte_count<=byte_count+1.
    - If last=1: go to DONE with finished.
    - Else if byte_count+1==MAX_BYTES: go to DONE with error.
    - Else: rom_address<=rom_address+1, go to FETCH.
  - If ack is already high on the first WRITE cycle, the write is accepted at that edge. Minimum 2 cycles per byte.
- DONE (1 cycle):
  - busy<=0.
  - finished<=1 on normal completion; error<=1 on MAX_BYTES exhaustion. finished and error are mutually exclusive.
  - Go to IDLE.
- Last-byte rule: the byte at the address where rom_done is high is still written, so a ROM with last address N produces N+1 writes.
- Ignored inputs:
  - start outside IDLE, including during DONE.
  - mem_write_ack outside WRITE.
  - rom_done outside FETCH.
- Restart: start in IDLE after a finish or error clears finished/error the cycle after acceptance and re-copies from address 0.
- Arithmetic:
  - All address and count math is 32-bit modulo 2^32.
  - BASE_ADDRESS+index wraps silently.
  - MAX_BYTES=0 is illegal and is not checked.

Test Plan:
- Reset then start, ROM last address 164, ack tied high -> 165 writes at mem_address 0..164; first four mem_data 1,0,0,0; byte 130 = 45; byte 148 = 135; finished=1, error=0, byte_count=165, busy low 2 cycles after the final ack.
- BASE_ADDRESS=32'h1000, ack delayed 3 cycles per write -> each request held 4 cycles with address and data stable; first write at 32'h1000 data 1; same totals as above.
- MAX_BYTES=16, rom_done never asserted -> exactly 16 writes, error=1, finished=0, byte_count=16.
- rst_n pulsed low while WRITE is pending at byte 50 -> request drops immediately; all outputs 0; no writes until the next start, which restarts at address 0.
- start pulsed repeatedly during the copy, and ack pulses injected while in IDLE/FETCH -> no restart, no extra byte_count increments, write sequence identical to the first scenario.
- Second start after finished -> finished clears, a full 165-byte copy repeats, finished=1 again.
